// File: rtl/main_fsm_ext.sv
// Multicycle RV32I main control FSM with jalr/lui/auipc, optional memory
// wait-states, an illegal-opcode trap and per-opcode immediate selection.
module main_fsm_ext #(
  parameter bit MEM_WAIT        = 1'b0,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter bit FENCE_AS_NOP    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       PCUpdate,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       Branch,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECR     = 4'd6,
    S_ALUWB     = 4'd7,
    S_EXECI     = 4'd8,
    S_JAL       = 4'd9,
    S_BRANCH    = 4'd10,
    S_JALR_CALC = 4'd11,
    S_JALR_JUMP = 4'd12,
    S_LUI       = 4'd13,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  state_t     state_q, state_d;
  logic       rdy;
  logic [2:0] imm_dec;
  state_t     illegal_next;

  // Without wait-states every memory access completes in one cycle.
  assign rdy = MEM_WAIT ? mem_ready : 1'b1;
  assign illegal_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
  assign state = state_q;

  // State register; reset forces FETCH immediately, aborting any access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Immediate format depends only on the opcode, whatever the state.
  always_comb begin
    imm_dec = 3'b000;
    case (op)
      OP_STORE:          imm_dec = 3'b001;
      OP_BRANCH:         imm_dec = 3'b010;
      OP_JAL:            imm_dec = 3'b011;
      OP_LUI, OP_AUIPC:  imm_dec = 3'b100;
      default:           imm_dec = 3'b000;
    endcase
  end

  // Next-state and datapath controls; everything idles at 0 by default.
  always_comb begin
    state_d   = S_FETCH;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    PCUpdate  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    Branch    = 1'b0;
    ALUOp     = 2'b00;
    ImmSrc    = imm_dec;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        // IR load and PC+4 only on the completing cycle, never while stalled.
        IRWrite   = rdy;
        PCUpdate  = rdy;
        state_d   = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JALR:           state_d = S_JALR_CALC;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          OP_FENCE:          state_d = FENCE_AS_NOP ? S_FETCH : illegal_next;
          default:           state_d = illegal_next;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (op == OP_LOAD)       state_d = S_MEMREAD;
        else if (op == OP_STORE) state_d = S_MEMWRITE;
        else                     state_d = S_FETCH;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_JAL, S_JALR_JUMP: begin
        // PC takes the target in ALUOut while the ALU forms OldPC+4 for rd.
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
        state_d  = S_ALUWB;
      end
      S_JALR_CALC: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JALR_JUMP;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: begin
        ImmSrc  = 3'b000;
        state_d = S_FETCH;
      end
    endcase
  end

endmodule
